// File: rtl/keypad_operand_loader.sv
// keypad_operand_loader
//
// Debounces the decoded keypad stream from the row scanner and assembles two
// signed decimal operands (up to two digits each, range -99..99). The finished
// pair is offered to the multiplier through a valid/ready handshake.
//
// Ports
//   slow_clk     : single clock, all logic on its rising edge
//   rst          : synchronous, active-low reset
//   key_value    : digit / letter code from the row scanner
//   key_pressed  : any keypad row active
//   is_sign_key  : function code (000 digit, 100 '*', 010 '#', 001 'A',
//                  011 'B'/'C', 111 'D')
//   mult_ready   : multiplier can accept operands
//   operand_a    : operand A, two's complement, live during entry
//   operand_b    : operand B, two's complement, live during entry
//   op_valid     : operands are final, held until the handshake completes
//   entry_state  : FSM state (00 ENTRY_A, 01 ENTRY_B, 10 WAIT)
//   key_strobe   : one-cycle pulse per accepted key
//   neg_flag     : sign of the operand being entered (B's sign in WAIT)
//
// Handshake: op_valid rises after 'D' is accepted in ENTRY_B and stays high,
// with both operands frozen, until an edge where op_valid and mult_ready are
// both high. That edge is the transfer: everything clears and entry restarts
// in ENTRY_A. mult_ready while op_valid is low is ignored.

module keypad_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int OP_WIDTH        = 8
) (
  input  logic                slow_clk,
  input  logic                rst,
  input  logic [3:0]          key_value,
  input  logic                key_pressed,
  input  logic [2:0]          is_sign_key,
  input  logic                mult_ready,
  output logic [OP_WIDTH-1:0] operand_a,
  output logic [OP_WIDTH-1:0] operand_b,
  output logic                op_valid,
  output logic [1:0]          entry_state,
  output logic                key_strobe,
  output logic                neg_flag
);

  localparam logic [1:0] ST_ENTRY_A = 2'b00;
  localparam logic [1:0] ST_ENTRY_B = 2'b01;
  localparam logic [1:0] ST_WAIT    = 2'b10;

  localparam logic [2:0] FN_DIGIT  = 3'b000;
  localparam logic [2:0] FN_MINUS  = 3'b100;
  localparam logic [2:0] FN_PLUS   = 3'b010;
  localparam logic [2:0] FN_NEXT   = 3'b001;
  localparam logic [2:0] FN_CLEAR  = 3'b011;
  localparam logic [2:0] FN_EQUALS = 3'b111;

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_CYCLES);

  // Debounce / arm tracking
  logic [6:0] r_code;
  logic [3:0] r_cnt;
  logic [3:0] r_idle;
  logic       r_armed;

  // Entry state
  logic [1:0] r_state;
  logic [6:0] r_mag_a, r_mag_b;
  logic       r_neg_a, r_neg_b;
  logic [1:0] r_dig_a, r_dig_b;
  logic       r_op_valid;
  logic       r_strobe;

  logic [6:0] w_code;
  logic [3:0] w_cnt_next;
  logic       w_accept;

  logic [6:0] w_cur_mag, w_nxt_mag;
  logic       w_cur_neg, w_nxt_neg;
  logic [1:0] w_cur_dig, w_nxt_dig;
  logic [1:0] w_nxt_state;
  logic       w_set_valid;
  logic       w_act;

  assign w_code = {is_sign_key, key_value};

  // The scanner freezes while a row is active, so a count of identical
  // consecutive high samples is a clean press. cnt==0 marks "previous sample
  // was low", which restarts the count even when the code matches.
  always_comb begin
    w_cnt_next = 4'd0;
    w_accept   = 1'b0;
    if (r_armed && key_pressed) begin
      if (r_cnt != 4'd0 && w_code == r_code) begin
        w_cnt_next = r_cnt + 4'd1;
      end else begin
        w_cnt_next = 4'd1;
      end
      w_accept = (w_cnt_next == DB_TARGET);
    end
  end

  // Key actions operate on whichever operand is being entered.
  always_comb begin
    w_cur_mag   = (r_state == ST_ENTRY_B) ? r_mag_b : r_mag_a;
    w_cur_neg   = (r_state == ST_ENTRY_B) ? r_neg_b : r_neg_a;
    w_cur_dig   = (r_state == ST_ENTRY_B) ? r_dig_b : r_dig_a;
    w_nxt_mag   = w_cur_mag;
    w_nxt_neg   = w_cur_neg;
    w_nxt_dig   = w_cur_dig;
    w_nxt_state = r_state;
    w_set_valid = 1'b0;
    w_act       = 1'b0;
    if (w_accept && r_state != ST_WAIT) begin
      case (is_sign_key)
        FN_DIGIT: begin
          if (key_value <= 4'd9) begin
            w_act = 1'b1;
            // A third digit is swallowed; mag stays within 0..99.
            if (w_cur_dig < 2'd2) begin
              w_nxt_mag = w_cur_mag * 7'd10 + {3'b000, key_value};
              w_nxt_dig = w_cur_dig + 2'd1;
            end
          end
        end
        FN_MINUS: begin
          w_act     = 1'b1;
          w_nxt_neg = 1'b1;
        end
        FN_PLUS: begin
          w_act     = 1'b1;
          w_nxt_neg = 1'b0;
        end
        FN_NEXT: begin
          w_act = 1'b1;
          if (r_state == ST_ENTRY_A) w_nxt_state = ST_ENTRY_B;
        end
        FN_CLEAR: begin
          w_act     = 1'b1;
          w_nxt_mag = 7'd0;
          w_nxt_neg = 1'b0;
          w_nxt_dig = 2'd0;
        end
        FN_EQUALS: begin
          w_act = 1'b1;
          if (r_state == ST_ENTRY_B) begin
            w_nxt_state = ST_WAIT;
            w_set_valid = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge slow_clk) begin
    if (!rst) begin
      r_code     <= 7'd0;
      r_cnt      <= 4'd0;
      r_idle     <= 4'd0;
      r_armed    <= 1'b1;
      r_state    <= ST_ENTRY_A;
      r_mag_a    <= 7'd0;
      r_mag_b    <= 7'd0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_dig_a    <= 2'd0;
      r_dig_b    <= 2'd0;
      r_op_valid <= 1'b0;
      r_strobe   <= 1'b0;
    end else begin
      r_code   <= w_code;
      r_strobe <= w_act;

      // Debounce runs in every state so a key held across the handshake is
      // not accepted a second time.
      if (r_armed) begin
        r_idle <= 4'd0;
        if (w_accept) begin
          r_armed <= 1'b0;
          r_cnt   <= 4'd0;
        end else begin
          r_cnt <= w_cnt_next;
        end
      end else begin
        r_cnt <= 4'd0;
        if (key_pressed) begin
          r_idle <= 4'd0;
        end else if (r_idle + 4'd1 == DB_TARGET) begin
          r_idle  <= 4'd0;
          r_armed <= 1'b1;
        end else begin
          r_idle <= r_idle + 4'd1;
        end
      end

      if (r_state == ST_WAIT) begin
        if (r_op_valid && mult_ready) begin
          r_state    <= ST_ENTRY_A;
          r_op_valid <= 1'b0;
          r_mag_a    <= 7'd0;
          r_mag_b    <= 7'd0;
          r_neg_a    <= 1'b0;
          r_neg_b    <= 1'b0;
          r_dig_a    <= 2'd0;
          r_dig_b    <= 2'd0;
        end
      end else begin
        r_state <= w_nxt_state;
        if (w_set_valid) r_op_valid <= 1'b1;
        if (r_state == ST_ENTRY_B) begin
          r_mag_b <= w_nxt_mag;
          r_neg_b <= w_nxt_neg;
          r_dig_b <= w_nxt_dig;
        end else begin
          r_mag_a <= w_nxt_mag;
          r_neg_a <= w_nxt_neg;
          r_dig_a <= w_nxt_dig;
        end
      end
    end
  end

  // Sign-magnitude to two's complement; a negative zero encodes as zero.
  function automatic logic [OP_WIDTH-1:0] encode(input logic [6:0] mag,
                                                 input logic       neg);
    logic [OP_WIDTH-1:0] v;
    v = {{(OP_WIDTH-7){1'b0}}, mag};
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign operand_a   = encode(r_mag_a, r_neg_a);
  assign operand_b   = encode(r_mag_b, r_neg_b);
  assign op_valid    = r_op_valid;
  assign entry_state = r_state;
  assign key_strobe  = r_strobe;
  assign neg_flag    = (r_state == ST_ENTRY_A) ? r_neg_a : r_neg_b;

endmodule

// File: tb/tb_keypad_operand_loader.sv
module tb_keypad_operand_loader;

  localparam int DB = 4;

  localparam logic [6:0] K_STAR = 7'b100_1110;
  localparam logic [6:0] K_HASH = 7'b010_1111;
  localparam logic [6:0] K_A    = 7'b001_1010;
  localparam logic [6:0] K_C    = 7'b011_1100;
  localparam logic [6:0] K_D    = 7'b111_1101;

  // ---------------- clock / reset / DUT ----------------
  logic       slow_clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_value = 4'd0;
  logic       key_pressed = 1'b0;
  logic [2:0] is_sign_key = 3'd0;
  logic       mult_ready = 1'b0;
  logic [7:0] operand_a, operand_b;
  logic       op_valid;
  logic [1:0] entry_state;
  logic       key_strobe;
  logic       neg_flag;

  always #5 slow_clk = ~slow_clk;

  keypad_operand_loader #(.DEBOUNCE_CYCLES(DB), .OP_WIDTH(8)) dut (
    .slow_clk    (slow_clk),
    .rst         (rst),
    .key_value   (key_value),
    .key_pressed (key_pressed),
    .is_sign_key (is_sign_key),
    .mult_ready  (mult_ready),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .op_valid    (op_valid),
    .entry_state (entry_state),
    .key_strobe  (key_strobe),
    .neg_flag    (neg_flag)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [18:0] exp_q[$];   // {entry_state, neg_flag, operand_a, operand_b}
  logic [15:0] xfer_q[$];  // {operand_a, operand_b} at transfer
  logic [6:0]  bpat;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] snap(input logic [1:0] st, input logic ng,
                                       input logic [7:0] a, input logic [7:0] b);
    return {st, ng, a, b};
  endfunction

  function automatic logic [6:0] dig(input int n);
    return {3'b000, 4'(n)};
  endfunction

  // ---------------- driver tasks ----------------
  // One sample: inputs applied, then one rising edge, return 1ns later.
  task automatic sample(input logic kp, input logic [6:0] code);
    key_pressed = kp;
    {is_sign_key, key_value} = code;
    @(posedge slow_clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] code, input int n, input int strobe_at);
    for (int i = 0; i < n; i++) begin
      sample(1'b1, code);
      check("strobe_timing", key_strobe, (i == strobe_at));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sample(1'b0, 7'd0);
  endtask

  task automatic tap(input logic [6:0] code, input logic [18:0] e);
    exp_q.push_back(e);
    hold(code, DB, DB - 1);
    idle(DB);
  endtask

  task automatic tap_silent(input logic [6:0] code);
    hold(code, DB, -1);
    idle(DB);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge slow_clk);
      if (key_strobe) begin
        if (exp_q.size() == 0) check("strobe_with_empty_queue", key_strobe, 0);
        else check("key_result", snap(entry_state, neg_flag, operand_a, operand_b),
                   exp_q.pop_front());
      end
      if (op_valid && mult_ready) begin
        if (xfer_q.size() == 0) check("unexpected_transfer", op_valid, 0);
        else check("transfer", {operand_a, operand_b}, xfer_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0;
    idle(2);
    check("reset_outputs",
          {operand_a, operand_b, op_valid, entry_state, key_strobe, neg_flag}, 0);
    rst = 1'b1;

    // Short press (3 < DB samples) is rejected.
    hold(dig(4), 3, -1);
    idle(DB);
    check("short_press_a", operand_a, 8'h00);

    // Long hold: exactly one acceptance on the 4th sample.
    exp_q.push_back(snap(2'b00, 1'b0, 8'h04, 8'h00));
    hold(dig(4), 10, DB - 1);
    idle(DB);
    check("hold_a", operand_a, 8'h04);

    // Clear, then -12 (third digit ignored), next, 5, equals.
    tap(K_C,    snap(2'b00, 1'b0, 8'h00, 8'h00));
    tap(K_STAR, snap(2'b00, 1'b1, 8'h00, 8'h00));
    tap(dig(1), snap(2'b00, 1'b1, 8'hFF, 8'h00));
    tap(dig(2), snap(2'b00, 1'b1, 8'hF4, 8'h00));
    tap(dig(3), snap(2'b00, 1'b1, 8'hF4, 8'h00));
    tap(K_A,    snap(2'b01, 1'b0, 8'hF4, 8'h00));
    tap(dig(5), snap(2'b01, 1'b0, 8'hF4, 8'h05));
    tap(K_D,    snap(2'b10, 1'b0, 8'hF4, 8'h05));
    check("op_valid_after_D", op_valid, 1'b1);
    check("state_wait", entry_state, 2'b10);

    // WAIT: keys ignored, operands frozen.
    idle(20);
    tap_silent(dig(7));
    check("wait_a_stable", operand_a, 8'hF4);
    check("wait_b_stable", operand_b, 8'h05);
    check("wait_valid_held", op_valid, 1'b1);

    xfer_q.push_back({8'hF4, 8'h05});
    mult_ready = 1'b1;
    sample(1'b0, 7'd0);
    mult_ready = 1'b0;
    check("post_transfer",
          {operand_a, operand_b, op_valid, entry_state, neg_flag}, 0);

    // 99, ready without valid is ignored, clear, D ignored in ENTRY_A.
    tap(dig(9), snap(2'b00, 1'b0, 8'h09, 8'h00));
    tap(dig(9), snap(2'b00, 1'b0, 8'h63, 8'h00));
    mult_ready = 1'b1;
    idle(3);
    mult_ready = 1'b0;
    check("ready_no_valid_a", operand_a, 8'h63);
    check("ready_no_valid_state", entry_state, 2'b00);
    tap(K_C, snap(2'b00, 1'b0, 8'h00, 8'h00));
    check("clear_neg", neg_flag, 1'b0);
    tap(K_D, snap(2'b00, 1'b0, 8'h00, 8'h00));
    check("d_ignored_state", entry_state, 2'b00);
    check("d_ignored_valid", op_valid, 1'b0);
    tap(K_STAR, snap(2'b00, 1'b1, 8'h00, 8'h00));
    tap(K_HASH, snap(2'b00, 1'b0, 8'h00, 8'h00));

    // Bounce 1,1,0,1,1,1,1 on '8': one acceptance on the last sample.
    bpat = 7'b1101111;
    exp_q.push_back(snap(2'b00, 1'b0, 8'h08, 8'h00));
    for (int i = 0; i < 7; i++) begin
      sample(bpat[6-i], dig(8));
      check("bounce_strobe", key_strobe, (i == 6));
    end
    // Release glitch leaves only 3 clean lows: still disarmed.
    bpat = 7'b0010000;
    for (int i = 0; i < 6; i++) sample(bpat[6-i], dig(8));
    hold(dig(8), DB, -1);
    idle(DB);
    exp_q.push_back(snap(2'b00, 1'b0, 8'h58, 8'h00));
    hold(dig(8), DB, DB - 1);
    idle(DB);

    // Reset mid-entry with operand_a = -7, key held across reset.
    tap(K_C,    snap(2'b00, 1'b0, 8'h00, 8'h00));
    tap(K_STAR, snap(2'b00, 1'b1, 8'h00, 8'h00));
    tap(dig(7), snap(2'b00, 1'b1, 8'hF9, 8'h00));
    check("minus_seven", operand_a, 8'hF9);
    hold(dig(5), 2, -1);
    rst = 1'b0;
    sample(1'b1, dig(5));
    check("reset_mid_press",
          {operand_a, operand_b, op_valid, entry_state, key_strobe, neg_flag}, 0);
    rst = 1'b1;
    exp_q.push_back(snap(2'b00, 1'b0, 8'h05, 8'h00));
    hold(dig(5), DB, DB - 1);
    idle(DB);

    // Reset in WAIT aborts the pending transfer.
    tap(K_A, snap(2'b01, 1'b0, 8'h05, 8'h00));
    tap(K_D, snap(2'b10, 1'b0, 8'h05, 8'h00));
    rst = 1'b0;
    sample(1'b0, 7'd0);
    check("reset_in_wait",
          {operand_a, operand_b, op_valid, entry_state, key_strobe, neg_flag}, 0);
    rst = 1'b1;

    idle(DB);
    check("exp_queue_drained", exp_q.size(), 0);
    check("xfer_queue_drained", xfer_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_operand_loader.md
# keypad_operand_loader

Consumes the decoded keypad stream from the row scanner (`key_value`, `key_pressed`, `is_sign_key`) and debounces each press. It assembles two signed decimal operands of up to two digits each, then hands them to the Booth multiplier through a valid/ready handshake. It sits between the row scanner and the multiplier core, and also drives the operand/display path.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive identical samples required to accept a press; also the number of consecutive idle samples required to re-arm after release. Legal range 1..15.
- `OP_WIDTH`, 8: operand width, signed two's complement. Must be ≥ 8.

Ports:
- `slow_clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `key_value` in 4: digit or letter code from the row scanner.
- `key_pressed` in 1: any row active.
- `is_sign_key` in 3: function code. 000 digit, 100 `*` (minus), 010 `#` (plus), 001 `A` (next operand), 011 `B`/`C` (clear entry), 111 `D` (equals).
- `mult_ready` in 1: multiplier can accept operands.
- `operand_a` out OP_WIDTH: current/final operand A.
- `operand_b` out OP_WIDTH: current/final operand B.
- `op_valid` out 1: operands final; held until handshake.
- `entry_state` out 2: 00 ENTRY_A, 01 ENTRY_B, 10 WAIT.
- `key_strobe` out 1: one-cycle pulse per accepted key.
- `neg_flag` out 1: sign of the operand currently being entered.

## Operation
- The system scan halts while any row is active, so the code `{is_sign_key, key_value}` is steady for the duration of a physical press.
- **Debounce counter and arm flag:**
  - While armed: a sample with `key_pressed=1` and the same code as the previous sample increments the count.
  - A sample with a changed code restarts the count at 1.
  - A sample with `key_pressed=0` clears the count.
  - When the count reaches DEBOUNCE_CYCLES, the key is accepted and the flag is disarmed.
- **Re-arm:** once disarmed, the flag re-arms after DEBOUNCE_CYCLES consecutive samples with `key_pressed=0`. Any high sample restarts the idle count. A held key is therefore accepted exactly once.
- **Accepted key actions:**
  - Digit (000, value 0..9): if the current operand has fewer than 2 digits, `mag = mag*10 + value` and the digit count increments. A third digit is ignored, but `key_strobe` still pulses.
  - `*` (100): neg=1. `#` (010): neg=0. Either may be pressed at any point during entry.
  - `A` (001): in ENTRY_A, advance to ENTRY_B. With zero digits entered, A = 0. Ignored in ENTRY_B.
  - `B`/`C` (011): clear the current operand (mag=0, neg=0, digits=0). The other operand is untouched.
  - `D` (111): in ENTRY_B, go to WAIT and set `op_valid=1`. Ignored in ENTRY_A.
  - Any other code: ignored, no strobe.
- **Operand encoding:** `operand_x = neg ? -mag : mag`, sign-extended to OP_WIDTH. The range is -99..99. `-0` encodes as 0.
- `operand_a`/`operand_b` update live during entry.
- `neg_flag` reflects the operand currently being entered. In WAIT it shows B's sign.
- **FSM transitions:**
  - ENTRY_A → ENTRY_B on `A`.
  - ENTRY_B → WAIT on `D`.
  - WAIT → ENTRY_A on `op_valid & mult_ready` at a clock edge. On that edge, both operands, both signs and both digit counts clear, and `op_valid` drops.
- **WAIT behaviour:**
  - All keys are ignored and produce no strobe.
  - Debounce and arm tracking continue, so a key held across the handshake is not re-accepted.
  - `operand_a`/`operand_b` are stable while `op_valid=1`.

## Timing
- Reset (`rst=0` at an edge): on the same edge, all outputs go to 0, `entry_state`=00, counters clear and arm=1. Reset mid-press or mid-WAIT aborts everything.
- A key held through reset release needs DEBOUNCE_CYCLES fresh samples after release.
- Acceptance latency: the first high sample is at edge k. On edge k+DEBOUNCE_CYCLES-1 the operand, state and neg registers update, and `key_strobe` is high for exactly that following cycle. With DEBOUNCE_CYCLES=1, the key is accepted on the first sample.
- Handshake: `op_valid` rises the cycle after `D` is accepted. The transfer occurs on the first edge where both signals are high. `mult_ready` high while `op_valid` is low has no effect.
- Minimum spacing between accepted keys: 2·DEBOUNCE_CYCLES cycles.

## Test plan
- Reset then press `4` for 3 cycles (DEBOUNCE_CYCLES=4) → no strobe, `operand_a`=0. Next, hold for 10 cycles → exactly one strobe, on the 4th sample; `operand_a`=4.
- Enter `*`,`1`,`2`,`3`,`A`,`5`,`D` → `operand_a`=8'hF4 (-12), `operand_b`=5, `op_valid`=1, `entry_state`=10.
- In WAIT with `mult_ready=0` for 20 cycles, press `7` → operands unchanged, no strobe. Then raise `mult_ready` → one-cycle transfer; next cycle `op_valid`=0, both operands 0, `entry_state`=00.
- Enter `9`,`9`,`C` → `operand_a`=0, neg=0. Then `D` → ignored, state stays 00.
- Bounce pattern `key_pressed` 1,1,0,1,1,1,1 on `8` → a single acceptance on the last sample. Release with a glitch 0,0,1,0,0,0,0 then press `8` → second acceptance only after 4 clean low samples.
- Assert `rst` low for one edge mid-entry with `operand_a`=-7 → all outputs 0, state 00 on the same edge.
